// File: rtl/fifo_pkt_drain.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkt_drain
//  Purpose  : Read side of a first-word-fallthrough FIFO. Pops {ctrl,data}
//             words while the FIFO is non-empty and downstream is ready, and
//             registers them onto the out_data/out_ctrl/out_wr module bus.
//             Tracks packet framing so that enable gating, packet counting
//             and the error flags act on whole packets.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_pkt_drain #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = 8,
  parameter int MAX_PKT_WORDS = 256,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout,
  input  logic                            fifo_empty,
  output logic                            fifo_rd_en,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [CTRL_WIDTH-1:0]           out_ctrl,
  output logic                            out_wr,
  input  logic                            out_rdy,
  input  logic                            enable,
  output logic [CNT_WIDTH-1:0]            pkt_cnt,
  output logic                            err_oversize,
  output logic                            err_framing
);

  // One extra bit beyond log2(MAX_PKT_WORDS) so the counter can hold the
  // limit itself and still count past it before saturating.
  localparam int                   WC_WIDTH = $clog2(MAX_PKT_WORDS) + 1;
  localparam logic [WC_WIDTH-1:0]  WC_MAX   = WC_WIDTH'(MAX_PKT_WORDS);
  localparam logic [WC_WIDTH-1:0]  WC_SAT   = {WC_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t                  state_q,        state_d;
  logic [WC_WIDTH-1:0]     word_cnt_q,     word_cnt_d;
  logic [DATA_WIDTH-1:0]   out_data_q,     out_data_d;
  logic [CTRL_WIDTH-1:0]   out_ctrl_q,     out_ctrl_d;
  logic                    out_wr_q,       out_wr_d;
  logic [CNT_WIDTH-1:0]    pkt_cnt_q,      pkt_cnt_d;
  logic                    err_oversize_q, err_oversize_d;
  logic                    err_framing_q,  err_framing_d;

  logic [CTRL_WIDTH-1:0]   head_ctrl;
  logic [DATA_WIDTH-1:0]   head_data;
  logic                    head_ctrl_nz;
  logic                    pop;
  logic                    pop_eop;

  assign head_ctrl    = fifo_dout[CTRL_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign head_data    = fifo_dout[DATA_WIDTH-1:0];
  assign head_ctrl_nz = |head_ctrl;

  // enable only gates the start of a packet; reset_n is folded in so no pop
  // can be requested while the block is held in reset.
  assign pop        = reset_n & ~fifo_empty & out_rdy & ((state_q != S_IDLE) | enable);
  assign fifo_rd_en = pop;

  // A non-zero ctrl word while in payload marks the end of the packet.
  assign pop_eop = pop & (state_q == S_PAYLOAD) & head_ctrl_nz;

  // Next-state, output-register, counter and error-flag logic.
  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    out_data_d     = out_data_q;
    out_ctrl_d     = out_ctrl_q;
    out_wr_d       = pop;
    pkt_cnt_d      = pkt_cnt_q;
    err_oversize_d = err_oversize_q;
    err_framing_d  = err_framing_q;

    if (pop) begin
      out_data_d = head_data;
      out_ctrl_d = head_ctrl;

      case (state_q)
        S_IDLE: begin
          if (head_ctrl_nz) begin
            state_d = S_HDR;
          end else begin
            // Packet with no module header: still forwarded, but flagged.
            state_d       = S_PAYLOAD;
            err_framing_d = 1'b1;
          end
        end
        S_HDR: begin
          if (!head_ctrl_nz) begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (head_ctrl_nz) begin
            state_d   = S_IDLE;
            pkt_cnt_d = pkt_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // The limit-th word has already been counted; any further non-EOP
      // word means the packet is longer than allowed.
      if ((word_cnt_q == WC_MAX) && !pop_eop) begin
        err_oversize_d = 1'b1;
      end

      if (pop_eop) begin
        word_cnt_d = '0;
      end else if (word_cnt_q != WC_SAT) begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      word_cnt_q     <= '0;
      out_data_q     <= '0;
      out_ctrl_q     <= '0;
      out_wr_q       <= 1'b0;
      pkt_cnt_q      <= '0;
      err_oversize_q <= 1'b0;
      err_framing_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      out_data_q     <= out_data_d;
      out_ctrl_q     <= out_ctrl_d;
      out_wr_q       <= out_wr_d;
      pkt_cnt_q      <= pkt_cnt_d;
      err_oversize_q <= err_oversize_d;
      err_framing_q  <= err_framing_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_ctrl     = out_ctrl_q;
  assign out_wr       = out_wr_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign err_oversize = err_oversize_q;
  assign err_framing  = err_framing_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pkt_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_pkt_drain
//  Purpose  : Directed bench for fifo_pkt_drain. A behavioural FIFO model feeds
//             the DUT; every word written into it is queued as an expected
//             output and a negedge monitor compares each out_wr word in order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_pkt_drain;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int WW = DW + CW;

  logic          clk;
  logic          reset_n;
  logic [WW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy;
  logic          enable;
  logic [1:0]    pkt_cnt;
  logic          err_oversize;
  logic          err_framing;

  int total;
  int bad;
  int wr_seen;
  int words_pushed;

  logic [WW-1:0] fifo_q[$];
  logic [WW-1:0] exp_q[$];

  fifo_pkt_drain #(
    .DATA_WIDTH   (DW),
    .CTRL_WIDTH   (CW),
    .MAX_PKT_WORDS(4),
    .CNT_WIDTH    (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .out_data    (out_data),
    .out_ctrl    (out_ctrl),
    .out_wr      (out_wr),
    .out_rdy     (out_rdy),
    .enable      (enable),
    .pkt_cnt     (pkt_cnt),
    .err_oversize(err_oversize),
    .err_framing (err_framing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write one word into the FIFO model and queue it as an expected output.
  task automatic push_word(input logic [CW-1:0] c);
    logic [WW-1:0] w;
    w = {c, 64'hD00D_0000_0000_0000 + 64'(words_pushed)};
    words_pushed++;
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock cycle: present the FIFO head, sample the pop request, then pop
  // the model after the edge. Starts and ends just after a falling edge.
  task automatic tick(output logic popped);
    if (fifo_q.size() > 0) begin
      fifo_dout  = fifo_q[0];
      fifo_empty = 1'b0;
    end else begin
      fifo_empty = 1'b1;
    end
    #1;
    popped = fifo_rd_en;
    @(negedge clk);
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
  endtask

  task automatic run(input int n, input logic exp_pop, input string name);
    logic p;
    for (int i = 0; i < n; i++) begin
      tick(p);
      check(name, WW'(p), WW'(exp_pop));
    end
  endtask

  // Scoreboard monitor: every out_wr word must match the next expected word.
  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_word: got %0h expected none", {out_ctrl, out_data});
      end else begin
        check("out_word", {out_ctrl, out_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    total        = 0;
    bad          = 0;
    wr_seen      = 0;
    words_pushed = 0;
    reset_n      = 1'b0;
    out_rdy      = 1'b1;
    enable       = 1'b1;
    fifo_empty   = 1'b1;
    fifo_dout    = '0;
    @(negedge clk);

    // Reset held with a packet waiting and downstream ready.
    push_word(8'hFF); push_word(8'h00); push_word(8'h00); push_word(8'h00); push_word(8'h08);
    run(2, 1'b0, "rst_rd_en");
    check("rst_out_wr", WW'(out_wr), '0);
    check("rst_out_word", {out_ctrl, out_data}, '0);
    check("rst_pkt_cnt", WW'(pkt_cnt), '0);
    check("rst_errs", WW'({err_oversize, err_framing}), '0);

    // Single packet streams at one word per cycle.
    reset_n = 1'b1;
    run(5, 1'b1, "pktA_pop");
    check("pktA_pkt_cnt", WW'(pkt_cnt), WW'(1));

    // Backpressure in the middle of the payload.
    push_word(8'hFF); push_word(8'h00); push_word(8'h00); push_word(8'h00); push_word(8'h08);
    run(2, 1'b1, "pktB_pop_pre");
    out_rdy = 1'b0;
    run(1, 1'b0, "pktB_stall");
    check("pktB_stall_wr", WW'(out_wr), '0);
    run(2, 1'b0, "pktB_stall");
    out_rdy = 1'b1;
    run(3, 1'b1, "pktB_pop_post");
    check("pktB_pkt_cnt", WW'(pkt_cnt), WW'(2));

    // Enable dropped mid-packet with a second packet queued behind it.
    push_word(8'hFF); push_word(8'h00); push_word(8'h00); push_word(8'h00); push_word(8'h08);
    push_word(8'hFF); push_word(8'h00); push_word(8'h08);
    run(2, 1'b1, "pktC_pop_pre");
    enable = 1'b0;
    run(3, 1'b1, "pktC_finish");
    run(3, 1'b0, "pktD_held");
    check("pktC_pkt_cnt", WW'(pkt_cnt), WW'(3));
    check("pktD_in_fifo", WW'(fifo_q.size()), WW'(3));
    enable = 1'b1;
    run(3, 1'b1, "pktD_pop");
    check("pktD_pkt_cnt_wrap", WW'(pkt_cnt), WW'(0));
    check("no_errs_yet", WW'({err_oversize, err_framing}), '0);

    // Packet that starts with a payload word.
    push_word(8'h00); push_word(8'h00); push_word(8'h08);
    run(3, 1'b1, "pktE_pop");
    check("pktE_framing", WW'(err_framing), WW'(1));
    check("pktE_pkt_cnt", WW'(pkt_cnt), WW'(1));

    // Six-word packet against a limit of four.
    push_word(8'hFF); push_word(8'h00); push_word(8'h00); push_word(8'h00); push_word(8'h00); push_word(8'h08);
    run(4, 1'b1, "pktF_pop");
    check("pktF_oversize_early", WW'(err_oversize), WW'(0));
    run(1, 1'b1, "pktF_pop5");
    check("pktF_oversize", WW'(err_oversize), WW'(1));
    run(1, 1'b1, "pktF_pop6");
    check("pktF_pkt_cnt", WW'(pkt_cnt), WW'(2));

    // Counter wrap sequence, with an empty-FIFO stall inside one packet.
    push_word(8'hFF); push_word(8'h00); push_word(8'h08);
    run(3, 1'b1, "pktG_pop");
    check("pktG_pkt_cnt", WW'(pkt_cnt), WW'(3));
    push_word(8'hFF); push_word(8'h00);
    run(2, 1'b1, "pktH_pop_pre");
    run(2, 1'b0, "pktH_empty");
    check("pktH_empty_wr", WW'(out_wr), '0);
    push_word(8'h00); push_word(8'h08);
    run(2, 1'b1, "pktH_pop_post");
    check("pktH_pkt_cnt", WW'(pkt_cnt), WW'(0));
    push_word(8'hFF); push_word(8'h00); push_word(8'h08);
    run(3, 1'b1, "pktI_pop");
    check("pktI_pkt_cnt", WW'(pkt_cnt), WW'(1));
    check("errs_sticky", WW'({err_oversize, err_framing}), WW'(3));

    run(2, 1'b0, "tail_idle");
    check("words_out", WW'(wr_seen), WW'(words_pushed));
    check("exp_drained", WW'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
